// File: rtl/id_ex_pkg.sv
// Shared definitions for the ID->EX stage: default field widths,
// NOP encodings used to force bubbles, and the stage state encoding.
package id_ex_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int ALUOP_W_DEF   = 8;
  localparam int ALUSEL_W_DEF  = 3;
  localparam int REGADDR_W_DEF = 5;
  localparam int CNT_W_DEF     = 16;

  // NOP encodings: a bubble is an all-zero instruction that never writes.
  localparam logic [7:0]  EXE_NOP_OP    = 8'b0000_0000;
  localparam logic [2:0]  EXE_RES_NOP   = 3'b000;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
  localparam logic        WRITE_DISABLE = 1'b0;
  localparam logic [4:0]  NOP_REG_ADDR  = 5'b00000;

  // EMPTY: nothing held; FULL: main register valid; SKID: main and skid valid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipe_skid_reg.sv
// Payload-agnostic valid/ready pipeline register with optional two-entry
// skid buffer and flush. SKID=1 registers in_ready; SKID=0 passes it through.
module pipe_skid_reg
  import id_ex_pkg::*;
#(
  parameter int W    = 8,
  parameter bit SKID = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  stage_state_e state, state_nxt;
  logic [W-1:0] m_data, s_data;
  logic         load_m, load_s, move_s;
  logic         accept, issue;

  assign out_valid = (state != ST_EMPTY);
  assign out_data  = m_data;
  assign issue     = out_valid && out_ready;
  assign accept    = in_valid && in_ready;

  generate
    if (SKID) begin : g_skid
      logic ready_q;
      assign in_ready = ready_q;

      // Registered ready: low exactly while the skid entry is occupied.
      always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (rst) ready_q <= 1'b1;
        else     ready_q <= (state_nxt != ST_SKID);
      end
    end else begin : g_pass
      assign in_ready = !out_valid || out_ready;
    end
  endgenerate

  // Next-state and register-load decode; flush overrides everything.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    state_nxt = state;
    load_m    = 1'b0;
    load_s    = 1'b0;
    move_s    = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_nxt = ST_FULL;
          load_m    = 1'b1;
        end
      end
      ST_FULL: begin
        if (accept && issue) begin
          load_m = 1'b1;
        end else if (issue) begin
          state_nxt = ST_EMPTY;
        end else if (accept && SKID) begin
          state_nxt = ST_SKID;
          load_s    = 1'b1;
        end
      end
      ST_SKID: begin
        if (issue) begin
          state_nxt = ST_FULL;
          move_s    = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    if (flush) begin
      state_nxt = ST_EMPTY;
      load_m    = 1'b0;
      load_s    = 1'b0;
      move_s    = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_nxt;
  end

  // Payload registers; the skid entry always drains into main, preserving order.
  always_ff @(posedge clk) begin
    // NOTE: payload is not reset; validity lives in the state and the
    // consumer masks data whenever out_valid is low.
    if (load_m)      m_data <= in_data;
    else if (move_s) m_data <= s_data;
    if (load_s)      s_data <= in_data;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline stage: packs decode fields through pipe_skid_reg, forces
// NOPs onto the execute side when empty and counts back-pressured cycles.
module id_ex_stage
  import id_ex_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ALUOP_W   = ALUOP_W_DEF,
  parameter int ALUSEL_W  = ALUSEL_W_DEF,
  parameter int REGADDR_W = REGADDR_W_DEF,
  parameter bit SKID      = 1'b1,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 id_valid,
  output logic                 id_ready,
  input  logic [ALUOP_W-1:0]   id_aluop,
  input  logic [ALUSEL_W-1:0]  id_alusel,
  input  logic [DATA_W-1:0]    id_reg1,
  input  logic [DATA_W-1:0]    id_reg2,
  input  logic                 id_wreg,
  input  logic [REGADDR_W-1:0] id_wd,
  output logic                 ex_valid,
  input  logic                 ex_ready,
  output logic [ALUOP_W-1:0]   ex_aluop,
  output logic [ALUSEL_W-1:0]  ex_alusel,
  output logic [DATA_W-1:0]    ex_reg1,
  output logic [DATA_W-1:0]    ex_reg2,
  output logic                 ex_wreg,
  output logic [REGADDR_W-1:0] ex_wd,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam int PW = ALUOP_W + ALUSEL_W + 2 * DATA_W + 1 + REGADDR_W;

  logic [PW-1:0]        id_payload, ex_payload;
  logic [ALUOP_W-1:0]   pl_aluop;
  logic [ALUSEL_W-1:0]  pl_alusel;
  logic [DATA_W-1:0]    pl_reg1, pl_reg2;
  logic                 pl_wreg;
  logic [REGADDR_W-1:0] pl_wd;

  assign id_payload = {id_aluop, id_alusel, id_reg1, id_reg2, id_wreg, id_wd};
  assign {pl_aluop, pl_alusel, pl_reg1, pl_reg2, pl_wreg, pl_wd} = ex_payload;

  pipe_skid_reg #(
    .W    (PW),
    .SKID (SKID)
  ) u_reg (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (id_valid),
    .in_ready  (id_ready),
    .in_data   (id_payload),
    .out_valid (ex_valid),
    .out_ready (ex_ready),
    .out_data  (ex_payload)
  );

  // A bubble presents a NOP that can never write the register file.
  assign ex_aluop  = ex_valid ? pl_aluop  : ALUOP_W'(EXE_NOP_OP);
  assign ex_alusel = ex_valid ? pl_alusel : ALUSEL_W'(EXE_RES_NOP);
  assign ex_reg1   = ex_valid ? pl_reg1   : DATA_W'(ZERO_WORD);
  assign ex_reg2   = ex_valid ? pl_reg2   : DATA_W'(ZERO_WORD);
  assign ex_wreg   = ex_valid ? pl_wreg   : WRITE_DISABLE;
  assign ex_wd     = ex_valid ? pl_wd     : REGADDR_W'(NOP_REG_ADDR);

  // Saturating count of cycles the execute side held off a valid instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (ex_valid && !ex_ready && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: SKID=1 (16-bit and 4-bit counters) and SKID=0.
module tb_id_ex_stage;

  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic        wreg;
    logic [4:0]  wd;
  } instr_t;

  logic clk = 1'b0;
  logic rst, flush, id_valid, ex_ready, ex_ready0;
  logic [7:0] id_aluop; logic [2:0] id_alusel; logic [31:0] id_reg1, id_reg2;
  logic id_wreg; logic [4:0] id_wd;

  logic id_ready, ex_valid, ex_wreg; logic [7:0] ex_aluop; logic [2:0] ex_alusel;
  logic [31:0] ex_reg1, ex_reg2; logic [4:0] ex_wd; logic [15:0] stall_cnt;

  logic id_ready4, ex_valid4, ex_wreg4; logic [7:0] ex_aluop4; logic [2:0] ex_alusel4;
  logic [31:0] ex_reg14, ex_reg24; logic [4:0] ex_wd4; logic [3:0] stall_cnt4;

  logic id_ready0, ex_valid0, ex_wreg0; logic [7:0] ex_aluop0; logic [2:0] ex_alusel0;
  logic [31:0] ex_reg10, ex_reg20; logic [4:0] ex_wd0; logic [15:0] stall_cnt0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.SKID(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
    .id_aluop(id_aluop), .id_alusel(id_alusel), .id_reg1(id_reg1), .id_reg2(id_reg2),
    .id_wreg(id_wreg), .id_wd(id_wd), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_aluop(ex_aluop), .ex_alusel(ex_alusel), .ex_reg1(ex_reg1), .ex_reg2(ex_reg2),
    .ex_wreg(ex_wreg), .ex_wd(ex_wd), .stall_cnt(stall_cnt)
  );

  id_ex_stage #(.SKID(1'b1), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(id_ready4),
    .id_aluop(id_aluop), .id_alusel(id_alusel), .id_reg1(id_reg1), .id_reg2(id_reg2),
    .id_wreg(id_wreg), .id_wd(id_wd), .ex_valid(ex_valid4), .ex_ready(ex_ready),
    .ex_aluop(ex_aluop4), .ex_alusel(ex_alusel4), .ex_reg1(ex_reg14), .ex_reg2(ex_reg24),
    .ex_wreg(ex_wreg4), .ex_wd(ex_wd4), .stall_cnt(stall_cnt4)
  );

  id_ex_stage #(.SKID(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(id_ready0),
    .id_aluop(id_aluop), .id_alusel(id_alusel), .id_reg1(id_reg1), .id_reg2(id_reg2),
    .id_wreg(id_wreg), .id_wd(id_wd), .ex_valid(ex_valid0), .ex_ready(ex_ready0),
    .ex_aluop(ex_aluop0), .ex_alusel(ex_alusel0), .ex_reg1(ex_reg10), .ex_reg2(ex_reg20),
    .ex_wreg(ex_wreg0), .ex_wd(ex_wd0), .stall_cnt(stall_cnt0)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input instr_t i, input logic v);
    id_valid  = v;
    id_aluop  = i.aluop;
    id_alusel = i.alusel;
    id_reg1   = i.reg1;
    id_reg2   = i.reg2;
    id_wreg   = i.wreg;
    id_wd     = i.wd;
  endtask

  function automatic instr_t ex_pl();
    return {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wreg, ex_wd};
  endfunction

  function automatic instr_t ex_pl0();
    return {ex_aluop0, ex_alusel0, ex_reg10, ex_reg20, ex_wreg0, ex_wd0};
  endfunction

  function automatic instr_t rand_instr();
    instr_t r;
    r.aluop  = 8'($urandom);
    r.alusel = 3'($urandom);
    r.reg1   = $urandom;
    r.reg2   = $urandom;
    r.wreg   = 1'b1;
    r.wd     = 5'($urandom);
    return r;
  endfunction

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    instr_t a, b, c, x, y, z, ri;
    instr_t q[40];
    instr_t prev_pl;
    logic   prev_stall;
    int     sent, recv;

    a = '{aluop: 8'h25, alusel: 3'd1, reg1: 32'h1234, reg2: 32'hFF, wreg: 1'b1, wd: 5'd3};
    b = '{aluop: 8'h11, alusel: 3'd2, reg1: 32'hAAAA_0001, reg2: 32'h5, wreg: 1'b1, wd: 5'd7};
    c = '{aluop: 8'h3C, alusel: 3'd4, reg1: 32'hDEAD_BEEF, reg2: 32'h0, wreg: 1'b1, wd: 5'd31};
    x = '{aluop: 8'h21, alusel: 3'd3, reg1: 32'h1, reg2: 32'h2, wreg: 1'b1, wd: 5'd9};
    y = '{aluop: 8'h22, alusel: 3'd5, reg1: 32'h3, reg2: 32'h4, wreg: 1'b1, wd: 5'd10};
    z = '{aluop: 8'h23, alusel: 3'd6, reg1: 32'h5, reg2: 32'h6, wreg: 1'b1, wd: 5'd11};

    // Reset state, held and after release
    rst = 1'b1; flush = 1'b0; ex_ready = 1'b0; ex_ready0 = 1'b0;
    drive(a, 1'b0);
    tick(); tick();
    check("rst_ex_valid", ex_valid, 1'b0);
    check("rst_payload", ex_pl(), '0);
    check("rst_stall", stall_cnt, 16'd0);
    check("rst_id_ready", id_ready, 1'b1);
    rst = 1'b0;
    tick();
    check("post_rst_id_ready", id_ready, 1'b1);
    check("post_rst_ex_valid", ex_valid, 1'b0);

    // Single transfer
    drive(a, 1'b1); ex_ready = 1'b1;
    tick();
    check("xfer_valid", ex_valid, 1'b1);
    check("xfer_payload", ex_pl(), a);
    drive(a, 1'b0);
    tick();
    check("xfer_bubble_valid", ex_valid, 1'b0);
    check("xfer_bubble_payload", ex_pl(), '0);
    check("xfer_stall", stall_cnt, 16'd0);

    // Back-pressure: A in M, B in S, C held off
    ex_ready = 1'b0;
    drive(a, 1'b1);
    tick();
    check("bp_a_main", ex_pl(), a);
    check("bp_ready_full", id_ready, 1'b1);
    drive(b, 1'b1);
    tick();
    check("bp_a_still", ex_pl(), a);
    check("bp_ready_skid", id_ready, 1'b0);
    check("bp_stall1", stall_cnt, 16'd1);
    drive(c, 1'b1);
    tick();
    check("bp_hold_a", ex_pl(), a);
    check("bp_ready_hold", id_ready, 1'b0);
    check("bp_stall2", stall_cnt, 16'd2);
    tick();
    check("bp_stall3", stall_cnt, 16'd3);
    ex_ready = 1'b1;
    tick();
    check("bp_issue_b", ex_pl(), b);
    check("bp_ready_back", id_ready, 1'b1);
    tick();
    check("bp_issue_c", ex_pl(), c);
    check("bp_valid_c", ex_valid, 1'b1);
    drive(c, 1'b0);
    tick();
    check("bp_drained", ex_valid, 1'b0);
    check("bp_stall_final", stall_cnt, 16'd3);

    // Full-throughput stream
    pulse_rst();
    check("stream_stall_rst", stall_cnt, 16'd0);
    ex_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      ri = rand_instr();
      drive(ri, 1'b1);
      check("stream_id_ready", id_ready, 1'b1);
      tick();
      check("stream_payload", {ex_valid, ex_pl()}, {1'b1, ri});
    end
    drive(ri, 1'b0);
    tick();
    check("stream_stall", stall_cnt, 16'd0);
    check("stream_empty", ex_valid, 1'b0);

    // Flush while in SKID with a simultaneous accept attempt
    ex_ready = 1'b0;
    drive(x, 1'b1);
    tick();
    drive(y, 1'b1);
    tick();
    check("fl_in_skid", id_ready, 1'b0);
    drive(z, 1'b1); flush = 1'b1;
    tick();
    check("fl_ex_valid", ex_valid, 1'b0);
    check("fl_ex_wreg", ex_wreg, 1'b0);
    check("fl_payload", ex_pl(), '0);
    check("fl_id_ready", id_ready, 1'b1);
    check("fl_stall", stall_cnt, 16'd1);
    flush = 1'b0; drive(z, 1'b0); ex_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fl_no_issue", ex_valid, 1'b0);
    end

    // Flush in FULL with an accept that would otherwise land
    ex_ready = 1'b0;
    drive(x, 1'b1);
    tick();
    check("fl2_full", ex_pl(), x);
    drive(y, 1'b1); flush = 1'b1;
    tick();
    check("fl2_ex_valid", ex_valid, 1'b0);
    check("fl2_id_ready", id_ready, 1'b1);
    check("fl2_stall", stall_cnt, 16'd1);
    flush = 1'b0; drive(y, 1'b0); ex_ready = 1'b1;
    tick();
    check("fl2_discarded", ex_valid, 1'b0);

    // Stall counter saturation (4-bit instance) vs 16-bit instance
    pulse_rst();
    ex_ready = 1'b0;
    drive(a, 1'b1);
    tick();
    for (int i = 0; i < 10; i++) tick();
    check("sat_mid16", stall_cnt, 16'd10);
    check("sat_mid4", stall_cnt4, 4'd10);
    for (int i = 0; i < 6; i++) tick();
    check("sat_at16_4bit", stall_cnt4, 4'd15);
    for (int i = 0; i < 4; i++) tick();
    check("sat_end16", stall_cnt, 16'd20);
    check("sat_end4", stall_cnt4, 4'd15);
    drive(a, 1'b0);
    rst = 1'b1;
    tick();
    check("sat_rst_cnt4", stall_cnt4, 4'd0);
    check("sat_rst_cnt16", stall_cnt, 16'd0);
    check("sat_rst_valid", ex_valid4, 1'b0);
    rst = 1'b0;

    // SKID=0 instance with random execute back-pressure
    pulse_rst();
    for (int i = 0; i < 40; i++) q[i] = rand_instr();
    sent = 0; recv = 0; prev_stall = 1'b0; prev_pl = '0;
    for (int cyc = 0; cyc < 600 && recv < 40; cyc++) begin
      ex_ready0 = 1'($urandom_range(0, 1));
      if (sent < 40) drive(q[sent], 1'b1);
      else           drive(q[0], 1'b0);
      #1;
      check("s0_ready", id_ready0, !ex_valid0 || ex_ready0);
      if (prev_stall) check("s0_stable", ex_pl0(), prev_pl);
      if (ex_valid0 && ex_ready0) begin
        check("s0_order", ex_pl0(), q[recv]);
        recv++;
      end else if (!ex_valid0) begin
        check("s0_nop", ex_pl0(), '0);
      end
      prev_stall = ex_valid0 && !ex_ready0;
      prev_pl    = ex_pl0();
      if (id_valid && id_ready0) sent++;
      tick();
    end
    check("s0_all_issued", recv, 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Parametrised ID→EX pipeline register with a valid/ready handshake, an optional skid buffer, a flush input and a back-pressure stall counter.
- Sits between the decode stage and the ALU/execute stage.
- Carries aluop, alusel, both operands, the write-enable and the destination register address.
- Gives the pipeline true stall and flush support. A plain always-load register cannot stall or flush.

Parameters:
- DATA_W, 32: operand width (reg1/reg2).
- ALUOP_W, 8: aluop field width.
- ALUSEL_W, 3: alusel field width.
- REGADDR_W, 5: destination register address width.
- SKID, 1: 1 = two-entry skid buffer with fully registered id_ready; 0 = single register, id_ready combinational.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- flush  in  1  discard all held entries; wins over same-cycle input
- id_valid  in  1  decode presents an instruction
- id_ready  out  1  stage accepts this cycle
- id_aluop  in  ALUOP_W  ALU operation
- id_alusel  in  ALUSEL_W  result select
- id_reg1  in  DATA_W  operand 1
- id_reg2  in  DATA_W  operand 2
- id_wreg  in  1  register write enable
- id_wd  in  REGADDR_W  destination address
- ex_valid  out  1  execute-side instruction valid
- ex_ready  in  1  execute accepts
- ex_aluop  out  ALUOP_W
- ex_alusel  out  ALUSEL_W
- ex_reg1  out  DATA_W
- ex_reg2  out  DATA_W
- ex_wreg  out  1
- ex_wd  out  REGADDR_W
- stall_cnt  out  CNT_W  saturating count of back-pressured cycles

Interface: reset rst, synchronous, active-high; clock clk.

Behaviour:
- Handshakes:
  - Accept = id_valid && id_ready.
  - Issue = ex_valid && ex_ready.
  - Payload must stay stable while ex_valid && !ex_ready.
- Latency: an accepted instruction is on ex_* the next cycle if the stage was empty or issuing.
- NOP forcing: whenever ex_valid=0, all ex_* payload outputs are zero (NOP aluop/alusel, operands 0, wreg 0, wd 0). A bubble must never write the register file.
- Reset state, while rst=1 and after release:
  - ex_valid=0, payload 0, stall_cnt=0, internal state EMPTY.
  - id_ready=1 from the first cycle after reset.
  - Reset mid-transfer drops all held instructions.
- SKID=1 states (main register M, skid register S):
  - EMPTY: id_ready=1, ex_valid=0.
    - Accept → FULL (M loaded).
  - FULL: id_ready=1, ex_valid=1.
    - Accept and issue → FULL (M reloaded).
    - Issue only → EMPTY.
    - Accept only → SKID (input captured into S).
    - Neither → FULL.
  - SKID: id_ready=0, ex_valid=1.
    - Issue → FULL (S moves to M).
    - Otherwise hold.
  - id_ready is driven from a flop (state != SKID). There is no combinational path from ex_ready to id_ready.
- SKID=0:
  - Single register M.
  - id_ready = !ex_valid || ex_ready (combinational).
  - States EMPTY/FULL only.
- Flush:
  - Next state is EMPTY; M and S are invalidated.
  - The same-cycle accept is discarded, even though id_ready may have been 1.
  - Next cycle: ex_valid=0 and payload zero.
- Stall counter:
  - Increments each cycle ex_valid && !ex_ready and flush=0.
  - Saturates at all-ones, no wrap.
  - Cleared only by rst.
- Ordering: FIFO order is preserved. The skid entry always issues after M.

Decomposition:
- Shared package/defines, alongside the existing aluop/alusel/NOP definitions:
  - Default field widths.
  - NOP encodings used for forcing.
  - Stage state encoding (EMPTY/FULL/SKID).
- Natural sub-module: pipe_skid_reg. It is a generic payload-agnostic valid/ready register with a SKID parameter and flush. id_ex_stage packs the fields into one vector, instantiates it, and adds NOP forcing and stall_cnt. The same sub-module is reused later for ex_mem and mem_wb.

Test Plan:
- Reset then single transfer:
  - Stimulus: id_valid=1, aluop=0x25, alusel=1, reg1=0x1234, reg2=0xFF, wreg=1, wd=3, ex_ready=1.
  - Required: the next cycle shows ex_valid=1 with identical fields; the cycle after, ex_valid=0 and all ex_* zero.
- Back-pressure with SKID=1:
  - Stimulus: ex_ready=0, stream A, B, C.
  - Required: A sits in M, B is captured in S, id_ready=0 while C is held.
  - Then raise ex_ready: issue order A, B, C with no loss or duplication; stall_cnt equals the number of cycles ex_ready was low while valid.
- Full-throughput stream:
  - Stimulus: 100 random instructions, ex_ready=1 constant.
  - Required: one issue per cycle, id_ready never drops, stall_cnt=0.
- Flush while in SKID state with a simultaneous accept attempt.
  - Required: next cycle ex_valid=0, ex_wreg=0, id_ready=1; none of the three instructions ever issues.
- Stall counter saturation:
  - Stimulus: CNT_W=4, ex_ready=0 for 20 valid cycles.
  - Required: stall_cnt stops at 15.
  - Then pulse rst: stall_cnt=0, ex_valid=0.
- SKID=0 build:
  - Stimulus: random ex_ready toggling.
  - Required: id_ready == !ex_valid || ex_ready every cycle; payload stable while stalled; output sequence equals input sequence.
